// File: rtl/lru_set_assoc_cache.sv
// lru_set_assoc_cache: write-back, write-allocate set-associative cache
// with true-LRU replacement per set. Each line holds one VALUE_WIDTH word.
//
// Ports
//   clk, rst (async, active low)
//   core side : select, input_index, input_tag, new_value, RD_, WR_ (active low)
//               ready, done, cache_miss, rd_value
//   write-back: memwrite, wb_index, tag_write, value_write / mem_ack
//   fill      : memread, fill_index, fill_tag / mem_rdata, mem_rvalid
module lru_set_assoc_cache #(
    parameter int TAG_WIDTH   = 16,
    parameter int INDEX_WIDTH = 2,
    parameter int VALUE_WIDTH = 32,
    parameter int WAYS        = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   select,
    input  logic [INDEX_WIDTH-1:0] input_index,
    input  logic [TAG_WIDTH-1:0]   input_tag,
    input  logic [VALUE_WIDTH-1:0] new_value,
    input  logic                   RD_,
    input  logic                   WR_,
    output logic                   ready,
    output logic                   done,
    output logic                   cache_miss,
    output logic [VALUE_WIDTH-1:0] rd_value,
    output logic                   memwrite,
    output logic [INDEX_WIDTH-1:0] wb_index,
    output logic [TAG_WIDTH-1:0]   tag_write,
    output logic [VALUE_WIDTH-1:0] value_write,
    input  logic                   mem_ack,
    output logic                   memread,
    output logic [INDEX_WIDTH-1:0] fill_index,
    output logic [TAG_WIDTH-1:0]   fill_tag,
    input  logic [VALUE_WIDTH-1:0] mem_rdata,
    input  logic                   mem_rvalid
);
    localparam int SETS  = 1 << INDEX_WIDTH;
    localparam int AGE_W = $clog2(WAYS);

    typedef enum logic [2:0] {IDLE, COMPARE, WB, FILL, RESPOND} state_t;
    state_t state, state_nx;

    // Line state; tag/value are unreset storage.
    logic [SETS-1:0][WAYS-1:0]            valid, dirty;
    logic [SETS-1:0][WAYS-1:0][AGE_W-1:0] age;
    logic [TAG_WIDTH-1:0]                 tag_mem   [SETS][WAYS];
    logic [VALUE_WIDTH-1:0]               value_mem [SETS][WAYS];

    // Captured request
    logic [INDEX_WIDTH-1:0] req_index;
    logic [TAG_WIDTH-1:0]   req_tag;
    logic [VALUE_WIDTH-1:0] req_value;
    logic                   req_write;
    logic [AGE_W-1:0]       vic_way;

    logic                   accept;
    logic [WAYS-1:0]        hit_vec;
    logic                   hit, found_free, vic_dirty;
    logic [AGE_W-1:0]       hit_way, victim;

    // Line install / LRU touch controls
    logic                   inst_en, inst_dirty, touch_en;
    logic [AGE_W-1:0]       inst_way, touch_way;
    logic [VALUE_WIDTH-1:0] inst_val;

    assign ready  = (state == IDLE);
    assign accept = ready && select && (RD_ ^ WR_);

    for (genvar w = 0; w < WAYS; w++) begin : g_cmp
        assign hit_vec[w] = valid[req_index][w] && (tag_mem[req_index][w] == req_tag);
    end

    always_comb begin
        hit        = |hit_vec;
        hit_way    = '0;
        victim     = '0;
        found_free = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) hit_way = AGE_W'(w);
            if (!found_free && !valid[req_index][w]) begin
                victim     = AGE_W'(w);
                found_free = 1'b1;
            end
        end
        // Full set: the oldest way carries age WAYS-1.
        if (!found_free) begin
            for (int w = 0; w < WAYS; w++)
                if (age[req_index][w] == AGE_W'(WAYS-1)) victim = AGE_W'(w);
        end
        vic_dirty = valid[req_index][victim] && dirty[req_index][victim];
    end

    always_comb begin
        state_nx   = state;
        inst_en    = 1'b0;
        inst_way   = vic_way;
        inst_val   = req_value;
        inst_dirty = 1'b1;
        touch_en   = 1'b0;
        touch_way  = vic_way;
        case (state)
            IDLE: if (accept) state_nx = COMPARE;
            COMPARE: begin
                if (hit) begin
                    touch_en  = 1'b1;
                    touch_way = hit_way;
                    inst_en   = req_write;
                    inst_way  = hit_way;
                    state_nx  = RESPOND;
                end else if (vic_dirty) begin
                    state_nx = WB;
                end else if (req_write) begin
                    inst_en   = 1'b1;
                    inst_way  = victim;
                    touch_en  = 1'b1;
                    touch_way = victim;
                    state_nx  = RESPOND;
                end else begin
                    state_nx = FILL;
                end
            end
            WB: if (mem_ack) begin
                if (req_write) begin
                    inst_en  = 1'b1;
                    touch_en = 1'b1;
                    state_nx = RESPOND;
                end else begin
                    state_nx = FILL;
                end
            end
            FILL: if (mem_rvalid) begin
                inst_en    = 1'b1;
                inst_val   = mem_rdata;
                inst_dirty = 1'b0;
                touch_en   = 1'b1;
                state_nx   = RESPOND;
            end
            RESPOND: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            valid       <= '0;
            dirty       <= '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age[s][w] <= AGE_W'(w);
            req_index   <= '0;
            req_tag     <= '0;
            req_value   <= '0;
            req_write   <= 1'b0;
            vic_way     <= '0;
            done        <= 1'b0;
            cache_miss  <= 1'b0;
            rd_value    <= '0;
            memwrite    <= 1'b0;
            memread     <= 1'b0;
            wb_index    <= '0;
            tag_write   <= '0;
            value_write <= '0;
            fill_index  <= '0;
            fill_tag    <= '0;
        end else begin
            state    <= state_nx;
            // Request strobes are registered from next state so they are glitch-free.
            done     <= (state_nx == RESPOND);
            memwrite <= (state_nx == WB);
            memread  <= (state_nx == FILL);
            if (accept) begin
                req_index <= input_index;
                req_tag   <= input_tag;
                req_value <= new_value;
                req_write <= !WR_;
            end
            if (state == COMPARE) begin
                vic_way    <= victim;
                cache_miss <= !hit;
                if (hit && !req_write) rd_value <= value_mem[req_index][hit_way];
                if (!hit && vic_dirty) begin
                    wb_index    <= req_index;
                    tag_write   <= tag_mem[req_index][victim];
                    value_write <= value_mem[req_index][victim];
                end
                if (!hit && !req_write) begin
                    fill_index <= req_index;
                    fill_tag   <= req_tag;
                end
            end
            if (state == FILL && mem_rvalid) rd_value <= mem_rdata;
            if (inst_en) begin
                valid[req_index][inst_way] <= 1'b1;
                dirty[req_index][inst_way] <= inst_dirty;
            end
            // Ways younger than the touched one age by one; touched way becomes MRU.
            if (touch_en) begin
                for (int w = 0; w < WAYS; w++)
                    if (age[req_index][w] < age[req_index][touch_way])
                        age[req_index][w] <= age[req_index][w] + 1'b1;
                age[req_index][touch_way] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (inst_en) begin
            tag_mem[req_index][inst_way]   <= req_tag;
            value_mem[req_index][inst_way] <= inst_val;
        end
    end
endmodule
